// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, the NOP encoding and the fetch queue entry type.
package pipeline_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  typedef struct packed {
    logic [PC_W-1:0] pc_plus4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction
endpackage

// File: rtl/if_stage_fetch_if.sv
// if_stage_fetch_if: fetch stage control, instruction-memory and IF/ID presentation signals.
interface if_stage_fetch_if;
  import pipeline_pkg::*;
  logic freeze;
  logic br_taken;
  logic [PC_W-1:0] br_addr;
  logic imem_req;
  logic [PC_W-1:0] imem_addr;
  logic imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0] pc_out;
  modport master (
    input freeze, br_taken, br_addr, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr_valid, instr, pc_out
  );
  modport slave (
    output freeze, br_taken, br_addr, imem_rvalid, imem_rdata,
    input imem_req, imem_addr, instr_valid, instr, pc_out
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {pc+4, instr} entries; clear beats push.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  fetch_entry_t push_data,
  input  logic pop,
  input  logic clear,
  output fetch_entry_t head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      wp_q <= push ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp_q] <= push_data;
  end
  assign head = mem[rp_q];
  assign count = count_q;
endmodule

// File: rtl/if_stage_fetch.sv
// if_stage_fetch: in-order instruction fetch with prefetch queue, freeze and branch flush.
// Define IF_STALL_CNT_EN to add the stall_cycles/flush_cnt performance counters.
module if_stage_fetch
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic rst,
  if_stage_fetch_if.master bus
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, count;
  logic [CW:0] occ;
  logic issue, drop, push, pop;
  fetch_entry_t head, push_data;
  // queue slots are reserved at issue time, so a response can always be pushed
  assign occ = {1'b0, count} + {1'b0, out_q};
  assign issue = !rst && !bus.br_taken && occ < (CW+1)'(DEPTH);
  assign drop = bus.imem_rvalid && drop_q != '0;
  assign push = bus.imem_rvalid && !drop && !bus.br_taken;
  assign pop = bus.instr_valid && !bus.freeze && !bus.br_taken;
  assign push_data = '{pc_plus4: pc_inc(resp_pc_q), instr: bus.imem_rdata};
  always_comb begin
    out_d = out_q + CW'(issue) - CW'(bus.imem_rvalid);
    drop_d = bus.br_taken ? out_q - CW'(bus.imem_rvalid) : drop_q - CW'(drop);
    fetch_pc_d = bus.br_taken ? bus.br_addr : issue ? pc_inc(fetch_pc_q) : fetch_pc_q;
    resp_pc_d = bus.br_taken ? bus.br_addr : push ? pc_inc(resp_pc_q) : resp_pc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(push_data),
    .pop(pop),
    .clear(bus.br_taken),
    .head(head),
    .count(count)
  );
  assign bus.imem_req = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.instr_valid = count != '0;
  assign bus.instr = bus.instr_valid ? head.instr : NOP_INSTR;
  assign bus.pc_out = bus.instr_valid ? head.pc_plus4 : '0;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  always_comb begin
    stall_d = ((!bus.instr_valid || bus.freeze) && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    flush_d = bus.br_taken ? flush_q + 16'd1 : flush_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign stall_cycles = stall_q;
  assign flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_if_stage_fetch.sv
// tb_if_stage_fetch: directed vector bench for if_stage_fetch with a fixed-latency in-order imem model.
module tb_if_stage_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  if_stage_fetch_if bus ();
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_cnt;
`endif
  if_stage_fetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_cnt(flush_cnt)
`endif
  );
  typedef struct {
    logic [31:0] addr;
    int due;
  } pend_t;
  typedef struct {
    logic fr;
    logic req;
    logic [31:0] addr;
    logic v;
    logic [31:0] pc;
  } vec_t;
  pend_t pq[$];
  vec_t tv[18];
  int lat, cyc, stall_m, flush_m;
  int n_chk = 0;
  int n_fail = 0;
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    if (bus.imem_req) pq.push_back('{bus.imem_addr, cyc + lat});
    if (!bus.instr_valid || bus.freeze) stall_m++;
    if (bus.br_taken) flush_m++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus.br_taken = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = mem_f(pq[0].addr);
      void'(pq.pop_front());
    end
  endtask
  task automatic step(input string tag, input logic req, input logic [31:0] addr, input logic v,
                      input logic [31:0] pc);
    #1;
    chk($sformatf("%s.req", tag), {31'b0, bus.imem_req}, {31'b0, req});
    if (req) chk($sformatf("%s.addr", tag), bus.imem_addr, addr);
    chk($sformatf("%s.valid", tag), {31'b0, bus.instr_valid}, {31'b0, v});
    chk($sformatf("%s.pc_out", tag), bus.pc_out, v ? pc : 32'h0);
    chk($sformatf("%s.instr", tag), bus.instr, v ? mem_f(pc - 32'd4) : 32'h0);
    tick();
  endtask
  task automatic check_cnt(input string tag);
`ifdef IF_STALL_CNT_EN
    chk($sformatf("%s.stall_cycles", tag), stall_cycles, stall_m);
    chk($sformatf("%s.flush_cnt", tag), {16'b0, flush_cnt}, flush_m);
`else
    if (tag.len() == 0) $display("empty tag");
`endif
  endtask
  task automatic do_reset(input int l);
    lat = l;
    rst = 1'b1;
    bus.freeze = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_addr = '0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    pq.delete();
    @(negedge clk);
    @(negedge clk);
    chk("rst.req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst.valid", {31'b0, bus.instr_valid}, 32'h0);
    chk("rst.instr", bus.instr, 32'h0);
    chk("rst.pc_out", bus.pc_out, 32'h0);
    stall_m = 0;
    flush_m = 0;
    check_cnt("rst");
    rst = 1'b0;
    cyc = 1;
  endtask
  initial begin
    tv[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tv[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tv[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04};
    tv[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h08};
    tv[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h0C};
    tv[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h10};
    tv[6]  = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    tv[7]  = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};
    tv[8]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h14};
    tv[9]  = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h14};
    tv[10] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h14};
    tv[11] = '{1'b1, 1'b0, 32'h20, 1'b1, 32'h14};
    tv[12] = '{1'b0, 1'b0, 32'h20, 1'b1, 32'h14};
    tv[13] = '{1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
    tv[14] = '{1'b0, 1'b1, 32'h24, 1'b1, 32'h1C};
    tv[15] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h20};
    tv[16] = '{1'b0, 1'b1, 32'h2C, 1'b1, 32'h24};
    tv[17] = '{1'b0, 1'b1, 32'h30, 1'b1, 32'h28};
    // latency 1 streaming, then a six-cycle freeze that fills the queue
    do_reset(1);
    for (int i = 0; i < 18; i++) begin
      bus.freeze = tv[i].fr;
      step($sformatf("t1.c%0d", i + 1), tv[i].req, tv[i].addr, tv[i].v, tv[i].pc);
    end
    check_cnt("t1");
    // latency 3: request throttles at count+outstanding=4
    do_reset(3);
    step("t2.c1", 1'b1, 32'h00, 1'b0, 32'h0);
    step("t2.c2", 1'b1, 32'h04, 1'b0, 32'h0);
    step("t2.c3", 1'b1, 32'h08, 1'b0, 32'h0);
    step("t2.c4", 1'b1, 32'h0C, 1'b0, 32'h0);
    step("t2.c5", 1'b0, 32'h0, 1'b1, 32'h04);
    step("t2.c6", 1'b1, 32'h10, 1'b1, 32'h08);
    // latency 4 so that three requests are in flight with no response at the flush
    do_reset(4);
    step("t4.c1", 1'b1, 32'h00, 1'b0, 32'h0);
    step("t4.c2", 1'b1, 32'h04, 1'b0, 32'h0);
    step("t4.c3", 1'b1, 32'h08, 1'b0, 32'h0);
    bus.br_taken = 1'b1;
    bus.br_addr = 32'h100;
    step("t4.c4", 1'b0, 32'h0, 1'b0, 32'h0);
    step("t4.c5", 1'b1, 32'h100, 1'b0, 32'h0);
    step("t4.c6", 1'b1, 32'h104, 1'b0, 32'h0);
    step("t4.c7", 1'b1, 32'h108, 1'b0, 32'h0);
    step("t4.c8", 1'b1, 32'h10C, 1'b0, 32'h0);
    step("t4.c9", 1'b0, 32'h0, 1'b0, 32'h0);
    step("t4.c10", 1'b0, 32'h0, 1'b1, 32'h104);
    step("t4.c11", 1'b1, 32'h110, 1'b1, 32'h108);
    check_cnt("t4");
    // flush coincident with a response and freeze
    do_reset(3);
    step("t5.c1", 1'b1, 32'h00, 1'b0, 32'h0);
    step("t5.c2", 1'b1, 32'h04, 1'b0, 32'h0);
    step("t5.c3", 1'b1, 32'h08, 1'b0, 32'h0);
    step("t5.c4", 1'b1, 32'h0C, 1'b0, 32'h0);
    bus.freeze = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_addr = 32'h200;
    #1;
    chk("t5.c5.rvalid_seen", {31'b0, bus.imem_rvalid}, 32'h1);
    step("t5.c5", 1'b0, 32'h0, 1'b1, 32'h04);
    step("t5.c6", 1'b1, 32'h200, 1'b0, 32'h0);
    bus.freeze = 1'b0;
    step("t5.c7", 1'b1, 32'h204, 1'b0, 32'h0);
    step("t5.c8", 1'b1, 32'h208, 1'b0, 32'h0);
    step("t5.c9", 1'b1, 32'h20C, 1'b0, 32'h0);
    step("t5.c10", 1'b0, 32'h0, 1'b1, 32'h204);
    check_cnt("t5");
    // PC wrap at the top of the address space
    do_reset(1);
    bus.br_taken = 1'b1;
    bus.br_addr = 32'hFFFF_FFF8;
    step("t6.c1", 1'b0, 32'h0, 1'b0, 32'h0);
    step("t6.c2", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    step("t6.c3", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step("t6.c4", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC);
    step("t6.c5", 1'b1, 32'h4, 1'b1, 32'h0);
    step("t6.c6", 1'b1, 32'h8, 1'b1, 32'h4);
    check_cnt("t6");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
